fleet_placement_ctrl: RTL

Parametrised fleet-placement controller for the naval-battle game. It walks one or two players through placing every ship of a configurable fleet. For each ship the player chooses direction, orientation, X and Y, and the block then asks the external conflict validator to approve the placement. Approved pieces go to the board memory through a one-cycle write strobe, and `ready` is raised for the game-execution block once all placements are finished.

---
 rtl/fleet_placement_ctrl_if.sv | 25 ++
 rtl/fleet_placement_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fleet_placement_ctrl_if.sv
// Placement bus between the fleet controller, the conflict validator and the board memory.
interface fleet_placement_ctrl_if #(
    parameter int COORD_W = 4
);
    logic               val_req;
    logic               val_ack;
    logic               val_conflict;
    logic               store_we;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               dir;
    logic [2:0]         orient;
    logic [2:0]         piece_type;
    logic               player;

    modport master (
        output val_req, store_we, x, y, dir, orient, piece_type, player,
        input  val_ack, val_conflict
    );

    modport slave (
        input  val_req, store_we, x, y, dir, orient, piece_type, player,
        output val_ack, val_conflict
    );
endinterface

// File: rtl/fleet_placement_ctrl.sv
// Fleet-placement controller: walks one or two players through placing every ship of the fleet.
// Optional validator timeout with val_err output: define FLEET_PLACE_VAL_TIMEOUT_EN.
module fleet_placement_ctrl #(
    parameter int                   COORD_W     = 4,
    parameter int                   BOARD_N     = 10,
    parameter int                   N_TYPES     = 5,
    parameter logic [3*N_TYPES-1:0] TYPE_COUNTS = 15'b001_001_010_010_101,
    parameter int                   ORIENT_N    = 5,
    parameter int                   VAL_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   enter_n,
    input  logic                   select_n,
    input  logic                   mode,
    fleet_placement_ctrl_if.master bus,
    output logic                   ready,
    output logic [5:0]             state_onehot
`ifdef FLEET_PLACE_VAL_TIMEOUT_EN
    ,
    output logic                   val_err
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DIR    = 3'd1;
    localparam logic [2:0] ORIENT = 3'd2;
    localparam logic [2:0] DEF_X  = 3'd3;
    localparam logic [2:0] DEF_Y  = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] STORE  = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    logic [2:0]         state;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               dir_q;
    logic [2:0]         orient_q;
    logic [2:0]         type_q;
    logic               player_q;
    logic [2:0]         count;
    logic               mode_q;

    logic [1:0] ent_sync;
    logic [1:0] sel_sync;
    logic       ent_prev;
    logic       sel_prev;
    logic       ent_ev;
    logic       sel_ev;
    logic [3:0] nt;
    logic [3:0] first_type;
    logic       to_hit;

    function automatic logic [2:0] type_count(input logic [2:0] t);
        return TYPE_COUNTS[3*int'(t) +: 3];
    endfunction

    // First type at or after 'from' with a non-zero count; N_TYPES means none left.
    function automatic logic [3:0] next_type(input logic [3:0] from);
        logic [3:0] r;
        r = 4'(N_TYPES);
        for (int i = N_TYPES - 1; i >= 0; i--) begin
            if (i >= int'(from) && TYPE_COUNTS[3*i +: 3] != 3'd0) r = 4'(i);
        end
        return r;
    endfunction

    assign nt         = next_type(4'(type_q) + 4'd1);
    assign first_type = next_type(4'd0);

    // NOTE: synchroniser flops reset to 1 (button released) so reset release cannot fake a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_sync <= 2'b11;
            sel_sync <= 2'b11;
            ent_prev <= 1'b1;
            sel_prev <= 1'b1;
        end else begin
            ent_sync <= {ent_sync[0], enter_n};
            sel_sync <= {sel_sync[0], select_n};
            ent_prev <= ent_sync[1];
            sel_prev <= sel_sync[1];
        end
    end

    assign ent_ev = ent_prev & ~ent_sync[1];
    assign sel_ev = sel_prev & ~sel_sync[1];

`ifdef FLEET_PLACE_VAL_TIMEOUT_EN
    localparam int TO_W = $clog2(VAL_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (to_cnt == TO_W'(VAL_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt  <= '0;
            val_err <= 1'b0;
        end else begin
            val_err <= (state == CHECK) && enable && !bus.val_ack && to_hit;
            if ((state == CHECK) && enable && !bus.val_ack && !to_hit) to_cnt <= to_cnt + 1'b1;
            else                                                       to_cnt <= '0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            dir_q    <= 1'b0;
            orient_q <= '0;
            type_q   <= '0;
            player_q <= 1'b0;
            count    <= '0;
            mode_q   <= 1'b0;
        end else if (!enable && state != DONE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    mode_q <= mode;
                    state  <= DIR;
                end
                DIR: begin
                    if (ent_ev)      state <= ORIENT;
                    else if (sel_ev) dir_q <= ~dir_q;
                end
                ORIENT: begin
                    if (ent_ev)      state    <= DEF_X;
                    else if (sel_ev) orient_q <= (orient_q == 3'(ORIENT_N - 1)) ? 3'd0 : orient_q + 3'd1;
                end
                DEF_X: begin
                    if (ent_ev)      state <= DEF_Y;
                    else if (sel_ev) x_q   <= (x_q == COORD_W'(BOARD_N - 1)) ? '0 : x_q + 1'b1;
                end
                DEF_Y: begin
                    if (ent_ev)      state <= CHECK;
                    else if (sel_ev) y_q   <= (y_q == COORD_W'(BOARD_N - 1)) ? '0 : y_q + 1'b1;
                end
                CHECK: begin
                    if (bus.val_ack) state <= bus.val_conflict ? DEF_X : STORE;
                    else if (to_hit) state <= DEF_X;
                end
                STORE: begin
                    if (count + 3'd1 == type_count(type_q)) begin
                        count <= '0;
                        if (nt != 4'(N_TYPES)) begin
                            type_q <= nt[2:0];
                            state  <= DIR;
                        end else if (mode_q && !player_q) begin
                            player_q <= 1'b1;
                            type_q   <= first_type[2:0];
                            state    <= DIR;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        count <= count + 3'd1;
                        state <= DIR;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.val_req    = (state == CHECK);
    assign bus.store_we   = (state == STORE);
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.dir        = dir_q;
    assign bus.orient     = orient_q;
    assign bus.piece_type = type_q;
    assign bus.player     = player_q;
    assign ready          = (state == DONE);
    assign state_onehot   = {state == STORE, state == CHECK, state == DEF_Y,
                             state == DEF_X, state == ORIENT, state == DIR};

endmodule
